// File: rtl/req_encoder_32_pkg.sv
// Purpose : shared widths, FSM state type and the 5-to-32 index decoder for req_encoder_32.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: REQ_W, IDX_W, state_t {IDLE, BUSY}, idx2onehot().
package req_encoder_32_pkg;

   localparam int REQ_W = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // 5-to-32 one-hot decoder; the priority encoder is its inverse.
   function automatic logic [REQ_W-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
      logic [REQ_W-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/req_encoder_32_if.sv
// Purpose : mask-in / index-out handshake bundle for req_encoder_32, plus flush and err.
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready on the mask side, out_valid/out_ready on the index side.
// Modports: slave = the encoder block, master = the agent driving masks and consuming indices.
interface req_encoder_32_if;
   import req_encoder_32_pkg::*;

   logic             in_valid;
   logic [REQ_W-1:0] in_mask;
   logic             in_ready;
   logic             out_valid;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             out_ready;
   logic             flush;
   logic             err;

   modport slave (
      input  in_valid, in_mask, out_ready, flush,
      output in_ready, out_valid, out_idx, out_last, err
   );

   modport master (
      output in_valid, in_mask, out_ready, flush,
      input  in_ready, out_valid, out_idx, out_last, err
   );

endinterface

// File: rtl/z_prio_encoder_32.sv
// Purpose : 32-to-5 priority encoder; LOW_FIRST=1 picks the lowest set bit, 0 the highest.
// Latency : purely combinational.
// Backpressure: none.
// Ports   : vec_i (32b request vector) -> idx_o (5b index), any_o (some bit set),
//           one_left_o (exactly one bit set).
module z_prio_encoder_32
   import req_encoder_32_pkg::*;
#(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic [REQ_W-1:0] vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o,
   output logic             one_left_o
);

   // Scan toward the preferred end so the winning bit is the last one assigned.
   always_comb begin
      idx_o = '0;
      if (LOW_FIRST) begin
         for (int i = REQ_W - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < REQ_W; i++) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
         end
      end
   end

   assign any_o      = |vec_i;
   // Clearing the lowest set bit leaves zero only if a single bit was set.
   assign one_left_o = any_o && ((vec_i & (vec_i - REQ_W'(1))) == '0);

endmodule

// File: rtl/req_encoder_32.sv
// Purpose : accepts a 32-bit request mask and emits the index of every set bit, one per beat, in priority order.
// Latency : first index one cycle after acceptance; one index per cycle while out_ready is high.
// Backpressure: in_ready only in IDLE; out_idx/out_last held while out_valid & !out_ready.
// Ports   : clock, reset_n (async active-low), bus (req_encoder_32_if.slave).
// Config  : define REQ_ENC_ZERO_ERR_EN to add a sticky err flag set by accepting an all-zero mask.
module req_encoder_32
   import req_encoder_32_pkg::*;
#(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   req_encoder_32_if.slave      bus
);

   state_t           state_q, state_d;
   logic [REQ_W-1:0] pending_q, pending_d;

   logic [IDX_W-1:0] enc_idx;
   logic             enc_any;
   logic             enc_one_left;

   z_prio_encoder_32 #(
      .LOW_FIRST (LOW_FIRST)
   ) u_enc (
      .vec_i      (pending_q),
      .idx_o      (enc_idx),
      .any_o      (enc_any),
      .one_left_o (enc_one_left)
   );

`ifdef REQ_ENC_ZERO_ERR_EN
   logic err_q, err_d;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
`ifdef REQ_ENC_ZERO_ERR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
`ifdef REQ_ENC_ZERO_ERR_EN
         err_q     <= err_d;
`endif
      end
   end

   // Flush outranks both the output handshake and a mask acceptance.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
`ifdef REQ_ENC_ZERO_ERR_EN
      err_d     = err_q;
`endif
      if (bus.flush) begin
         state_d   = IDLE;
         pending_d = '0;
`ifdef REQ_ENC_ZERO_ERR_EN
         err_d     = 1'b0;
`endif
      end else if (state_q == IDLE) begin
         if (bus.in_valid) begin
            // A zero mask is loaded (pending stays 0) but never leaves IDLE.
            pending_d = bus.in_mask;
            state_d   = (bus.in_mask != '0) ? BUSY : IDLE;
`ifdef REQ_ENC_ZERO_ERR_EN
            if (bus.in_mask == '0) err_d = 1'b1;
`endif
         end
      end else begin
         if (bus.out_ready && enc_any) begin
            pending_d = pending_q & ~idx2onehot(enc_idx);
            if (enc_one_left) state_d = IDLE;
         end
      end
   end

   // Outputs depend only on registered state, never directly on inputs.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == BUSY);
   assign bus.out_idx   = (state_q == BUSY) ? enc_idx : '0;
   assign bus.out_last  = (state_q == BUSY) && enc_one_left;

`ifdef REQ_ENC_ZERO_ERR_EN
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: doc/req_encoder_32.md
REQ_ENCODER_32 -- requirements
Module: req_encoder_32

Interface
REQ-001 Parameter: LOW_FIRST, default 1, 1 = serve lowest set index first, 0 = serve highest set index first.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request mask offered.
REQ-005 in_mask  input  32  request vector; bit i requests index i.
REQ-006 in_ready  output  1  block can accept a new mask.
REQ-007 out_valid  output  1  out_idx holds a valid index.
REQ-008 out_idx  output  5  binary index of the bit being served.
REQ-009 out_last  output  1  current beat is the final index of the accepted mask.
REQ-010 out_ready  input  1  consumer accepts out_idx.
REQ-011 flush  input  1  synchronous abort of the mask being drained.
REQ-012 err  output  1  sticky zero-mask error flag (see Configuration).

Function
REQ-013 The block SHALL have two states: IDLE and BUSY.
REQ-014 IDLE SHALL drive in_ready=1 and out_valid=0; BUSY SHALL drive in_ready=0 and out_valid=1.
REQ-015 An in_valid&in_ready edge SHALL load in_mask into a 32-bit pending register.
REQ-016 The state SHALL go to BUSY on that edge only if the mask is nonzero; a zero mask SHALL leave the block in IDLE.
REQ-017 The first index SHALL be presented in the cycle after acceptance; there SHALL be no combinational path from any input to any output.
REQ-018 out_idx SHALL be the position of the lowest set pending bit (LOW_FIRST=1) or the highest set pending bit (LOW_FIRST=0).
REQ-019 out_last SHALL be 1 when exactly one pending bit remains.
REQ-020 out_idx and out_last SHALL remain stable while out_valid&!out_ready.
REQ-021 On an out_valid&out_ready edge, the block SHALL clear the served pending bit.
REQ-022 If the served beat has out_last=1, the block SHALL return to IDLE on that edge, so in_ready=1 in the next cycle and there is no bubble beyond one cycle.
REQ-023 A mask with k set bits SHALL produce exactly k beats, each index once, in strict priority order.
REQ-024 A mask of 0xFFFFFFFF SHALL yield indices 0..31 (LOW_FIRST=1); index 31 SHALL be encoded as 5'b11111 without wrap.
REQ-025 flush=1 SHALL clear pending and force IDLE on the next edge.
REQ-026 flush SHALL dominate a simultaneous output handshake and a simultaneous input acceptance; the mask offered in that cycle SHALL NOT be loaded.
REQ-027 When out_valid=0, out_idx and out_last SHALL be driven to 0.

Reset
REQ-028 reset_n low SHALL immediately (asynchronously) force IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, in_ready=1 and err=0.
REQ-029 Reset asserted mid-drain SHALL discard all remaining indices; no beat SHALL be emitted after release until a new mask is accepted.

Configuration
REQ-030 Macro REQ_ENC_ZERO_ERR_EN compiled in: accepting a zero mask SHALL set err on the next edge; err SHALL stay set until reset_n or flush.
REQ-031 Macro REQ_ENC_ZERO_ERR_EN absent: a zero mask SHALL be silently dropped, err SHALL be tied to 0, and no error register SHALL exist.

Structure
REQ-032 A shared package SHALL hold REQ_W=32, IDX_W=5, and the state enum {IDLE, BUSY}.
REQ-033 The priority encoder SHALL be one combinational sub-module, z_prio_encoder_32 (32-bit vector in; 5-bit index, any, and one-left out; direction selected by LOW_FIRST); it is the inverse of the team's 5-to-32 decoder.
REQ-034 The sequential wrapper SHALL contain only the pending register, the state register, and err.

Verification
REQ-035 in_mask=0x80000005 accepted, out_ready=1 held -> beats idx 0, 2, 31 on consecutive cycles; out_last only on 31; in_ready=1 on the following cycle.
REQ-036 in_mask=0x00000030, out_ready=0 for 3 cycles then 1 -> idx=4 held stable 3 cycles, then 4, 5 (last).
REQ-037 LOW_FIRST=0, in_mask=0x00010001 -> idx 16 then 0 (last).
REQ-038 in_mask=0xFFFFFFFF, flush pulsed on the 3rd beat together with out_ready -> only idx 0 and 1 are consumed; IDLE next cycle; a mask offered that cycle is ignored.
REQ-039 reset_n pulled low asynchronously mid-drain of 0x0000F000 -> outputs are 0 before the next clock edge; after release no beats occur until a new accept.
REQ-040 in_mask=0 accepted -> no beats; err=1 on the next cycle with REQ_ENC_ZERO_ERR_EN defined, err=0 without it.
